dmem_arbiter: RTL

- Shares the single data-memory port between the pipeline MEM stage (CPU) and a debug/loader port (DBG).
- Sits between the EX/MEM pipeline register outputs and the data memory instance.
- Drives a stall to the pipeline when the CPU loses arbitration.
- Also provides a halt mode in which the debug port owns the memory outright.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MEM stage (CPU) and a debug/loader port.
// Define DMEM_ARB_STARVE_EN to compile in the debug wait counter and the FORCE grant state.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int WAIT_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_valid,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ready,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  input  logic                  dbg_halt,
  output logic                  halted,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [2:0] LP_WORD_FUNCT3 = 3'b010;

  if ((WAIT_MAX < 1) || (WAIT_MAX > 255)) begin : g_wait_max_range
    $error("dmem_arbiter: WAIT_MAX must be in 1..255");
  end

`ifdef DMEM_ARB_STARVE_EN
  typedef enum logic [1:0] {
    ST_CPU_PRI = 2'd0,
    ST_FORCE   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  localparam logic [7:0] LP_WAIT_MAX  = 8'(WAIT_MAX);
  localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [7:0] r_wait_cnt;
`else
  typedef enum logic [1:0] {
    ST_CPU_PRI = 2'd0,
    ST_HALTED  = 2'd2
  } state_t;
`endif

  state_t r_state;
  state_t w_next_state;

  logic w_cpu_req;
  logic w_cpu_gnt;
  logic w_dbg_own;
  logic w_dbg_ready;
  logic w_dbg_rd_acc;

  assign w_cpu_req = cpu_rd | cpu_wr;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case/if leaves a value held and a latch inferred.
  always_comb begin
    w_next_state = r_state;
    w_cpu_gnt    = 1'b0;
    w_dbg_own    = 1'b0;
    cpu_stall    = 1'b0;

    case (r_state)
      ST_CPU_PRI: begin
        w_cpu_gnt = w_cpu_req;
        w_dbg_own = ~w_cpu_req;
        // A CPU store granted now completes this cycle; the halt takes effect
        // at the following edge, so the store is never lost.
        if (dbg_halt) begin
          w_next_state = ST_HALTED;
        end
`ifdef DMEM_ARB_STARVE_EN
        else if (dbg_valid && w_cpu_req && (r_wait_cnt == LP_WAIT_LAST)) begin
          w_next_state = ST_FORCE;
        end
`endif
      end
`ifdef DMEM_ARB_STARVE_EN
      ST_FORCE: begin
        w_dbg_own    = 1'b1;
        cpu_stall    = w_cpu_req;
        w_next_state = ST_CPU_PRI;
      end
`endif
      ST_HALTED: begin
        w_dbg_own = 1'b1;
        cpu_stall = w_cpu_req;
        if (!dbg_halt) begin
          w_next_state = ST_CPU_PRI;
        end
      end
      default: begin
        w_next_state = ST_CPU_PRI;
      end
    endcase

    // Nobody touches memory while reset is held.
    if (reset) begin
      w_cpu_gnt = 1'b0;
      w_dbg_own = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  assign w_dbg_ready  = w_dbg_own & dbg_valid;
  assign w_dbg_rd_acc = w_dbg_ready & ~dbg_we;
  assign dbg_ready    = w_dbg_ready;
  assign halted       = (r_state == ST_HALTED);
  assign cpu_rdata    = w_cpu_gnt ? mem_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order of always_ff blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CPU_PRI;
    end else begin
      r_state <= w_next_state;
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_dbg_ready || (r_state != ST_CPU_PRI)) begin
      r_wait_cnt <= '0;
    end else if (dbg_valid && (r_wait_cnt != LP_WAIT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`endif

  // Memory port mux; simultaneous CPU rd/wr resolves to the write.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    if (w_cpu_gnt) begin
      mem_wr     = cpu_wr;
      mem_rd     = cpu_rd & ~cpu_wr;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_funct3 = cpu_funct3;
    end else if (w_dbg_ready) begin
      mem_wr     = dbg_we;
      mem_rd     = ~dbg_we;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      mem_funct3 = LP_WORD_FUNCT3;
    end
  end

  // Debug read response: one-cycle pulse, data held until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= w_dbg_rd_acc;
      if (w_dbg_rd_acc) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule
